// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared state encoding and default widths for the req/gnt agent
package arb_pkg;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] REQ  = 2'b01;
  localparam logic [1:0] OWN  = 2'b10;
  localparam logic [1:0] REL  = 2'b11;

  localparam int LEN_W_DEF  = 8;
  localparam int WAIT_W_DEF = 8;

endpackage

// File: rtl/arb_req_cnt.sv
// rtl/arb_req_cnt.sv - loadable down-counter with one-detect, used for the owned-beat count
module arb_req_cnt #(
  parameter int W = 8
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         is_one_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Decrement stops at zero so a stray dec can never wrap the count.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign is_one_o = (count_q == W'(1));

endmodule

// File: rtl/arb_req_agent.sv
// rtl/arb_req_agent.sv - requester-side agent: start pulse to level request, owns the grant
// for exactly len cycles, then releases and waits for the grant to drop.
module arb_req_agent
  import arb_pkg::*;
#(
  parameter int LEN_W    = LEN_W_DEF,
  parameter int WAIT_W   = WAIT_W_DEF,
  parameter int MAX_WAIT = 200
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [LEN_W-1:0] burst_len_i,
  input  logic             abort_i,
  input  logic             gnt_i,
  output logic             req_o,
  output logic             active_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  logic [1:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              req_q, active_q, busy_q, done_q, err_q;
  logic              done_d, err_d;
  logic              cnt_load, cnt_dec, last_beat;
  logic [LEN_W-1:0]  eff_len;

  assign eff_len = (burst_len_i == '0) ? LEN_W'(1) : burst_len_i;

  // Beat count is loaded at start and simply held while waiting for grant.
  arb_req_cnt #(.W(LEN_W)) u_beat_cnt (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
    .load_i     (cnt_load),
    .load_val_i (eff_len),
    .dec_i      (cnt_dec),
    .is_one_o   (last_beat)
  );

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d  = REQ;
          wait_d   = '0;
          cnt_load = 1'b1;
        end
      end
      REQ: begin
        if (abort_i) begin
          state_d = REL;
          err_d   = 1'b1;
        end else if (gnt_i) begin
          state_d = OWN;
        end else if (wait_q == WAIT_W'(MAX_WAIT - 1)) begin
          state_d = REL;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      OWN: begin
        // A grant dropping on the final beat still counts as a completed burst.
        if (abort_i || (!gnt_i && !last_beat)) begin
          state_d = REL;
          err_d   = 1'b1;
        end else if (last_beat) begin
          state_d = REL;
          done_d  = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: begin
        if (!gnt_i) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      wait_q   <= '0;
      req_q    <= 1'b0;
      active_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      req_q    <= (state_d == REQ) || (state_d == OWN);
      active_q <= (state_d == OWN);
      busy_q   <= (state_d != IDLE);
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign req_o    = req_q;
  assign active_o = active_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign err_o    = err_q;

endmodule

// File: doc/arb_req_agent.md
Name: arb_req_agent

Overview:
- Requester-side agent for the 4-way req/gnt arbiter. It converts a one-cycle start command plus burst length into a level request, waits for grant, owns the resource for exactly N cycles, then releases.
- It waits for the grant to drop before accepting new work, and provides wait-timeout and lost-grant detection.
- One instance sits beside each client (agent 0..3) and drives that agent's req_x and receives its gnt_x.

Parameters:
- LEN_W, 8, width of burst length field.
- WAIT_W, 8, width of grant-wait counter.
- MAX_WAIT, 200, cycles in REQ without grant before timeout (must be at least 1 and at most 2**WAIT_W-1).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle command pulse; sampled only in IDLE.
- burst_len  input  LEN_W  owned cycles requested; 0 is treated as 1.
- abort  input  1  synchronous cancel, honoured in REQ and OWN.
- gnt  input  1  grant from arbiter.
- req  output  1  request to arbiter.
- active  output  1  high while agent owns the resource (OWN state).
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse: burst completed normally.
- err  output  1  one-cycle pulse: timeout, lost grant, or abort.

Behaviour:
- All outputs are registered. Reset (async, active-high) forces state=IDLE and req, active, busy, done, err = 0, and clears counters.
- IDLE:
  - On start=1 at an edge: latch len = (burst_len==0 ? 1 : burst_len), clear wait_cnt, go to REQ.
  - req and busy rise after that edge.
  - start while busy is ignored; there is no queueing.
- REQ:
  - req=1; wait_cnt increments each cycle.
  - gnt=1 sampled: go to OWN, load beat_cnt=len, active=1 next cycle.
  - abort=1: go to REL, err pulse.
  - wait_cnt==MAX_WAIT-1 with gnt=0: go to REL, err pulse (timeout).
  - Priority: abort > gnt > timeout.
- OWN:
  - req=1, active=1; beat_cnt decrements each cycle. OWN lasts exactly len cycles.
  - beat_cnt==1: go to REL, done pulse, req=0, active=0.
  - gnt=0 before last beat (lost grant): go to REL, err pulse.
  - abort: go to REL, err pulse.
  - Priority: abort > lost grant > completion. On the final beat with gnt still 1, done wins.
- REL:
  - req=0, busy=1; wait for gnt=0, then go to IDLE.
  - This guarantees the arbiter has passed through its IDLE state before the next request.
  - If gnt is already 0, go to IDLE on the next edge.
- done and err are never both high. Each is exactly one cycle wide, asserted in the first cycle of REL.
- Arbiter latency context: gnt rises 2 edges after req rises and falls 2 edges after req falls. Timing and tests assume this.
- Reset mid-burst drops req immediately (async) and returns to IDLE; no done/err is generated.
- Counters saturate-safe: wait_cnt never wraps, because timeout fires first.

Decomposition:
- Shared package arb_pkg:
  - state encoding constants IDLE=2'b00, REQ=2'b01, OWN=2'b10, REL=2'b11;
  - default widths LEN_W/WAIT_W.
- Optional sub-module arb_req_cnt: a loadable down-counter with zero/one detect, used for beat_cnt.
- The wait counter stays inline.

Test Plan:
- Reset mid-operation: assert reset while in OWN. req, active, busy drop asynchronously; after release the agent is IDLE and start works normally.
- Normal burst with arbiter model (gnt 2 edges after req): start, burst_len=4. active high exactly 4 cycles, done pulse once, req low thereafter, busy low after gnt falls. No err.
- burst_len=0: active is high exactly 1 cycle, then done.
- Timeout: MAX_WAIT=5, gnt held 0. req high 5 cycles, then err pulse, req=0, back to IDLE; done never asserts.
- Lost grant: burst_len=10, drop gnt after 3 active cycles. err pulse next cycle, req=0, no done.
- Abort and back-to-back:
  - abort in REQ gives err and req=0.
  - start during OWN is ignored.
  - A second start issued the cycle busy falls is accepted.
  - The agent waits in REL while gnt lingers 2 cycles, and req stays 0 throughout.
